div_unit: RTL and testbench

- Multi-cycle RV32M divide responder for the execute stage.
- Executes DIV, DIVU, REM and REMU, selected by funct3 values INST_DIV, INST_DIVU, INST_REM and INST_REMU from tinyriscv_pkg.
- Execute raises a request, holds the pipeline (Pipe_Pause) while busy_o is high, and writes back when ready_o pulses.
- Radix-2 restoring algorithm on operand magnitudes, one quotient bit per cycle; a Pipe_Clear flush aborts it.

---
 rtl/div_unit.sv | 196 +++++++++++++++++++
 tb/tb_div_unit.sv | 277 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/div_unit.sv
// div_unit: multi-cycle RV32M divide responder (DIV/DIVU/REM/REMU) for the execute stage.
// Radix-2 restoring division on operand magnitudes, one quotient bit per cycle.
module div_unit #(
   parameter int unsigned DataWidth = 32,
   parameter int unsigned AddrWidth = 5
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 start_i,
   input  logic [2:0]           op_i,
   input  logic [DataWidth-1:0] dividend_i,
   input  logic [DataWidth-1:0] divisor_i,
   input  logic [AddrWidth-1:0] reg_waddr_i,
   input  logic                 flush_i,
   output logic                 busy_o,
   output logic                 ready_o,
   output logic [DataWidth-1:0] result_o,
   output logic [AddrWidth-1:0] reg_waddr_o
);

   localparam int unsigned CntWidth = $clog2(DataWidth);
   localparam logic [CntWidth-1:0] LastCount = CntWidth'(DataWidth - 1);

   // funct3 encodings of the M-extension divide instructions
   localparam logic [2:0] INST_DIV  = 3'b100;
   localparam logic [2:0] INST_DIVU = 3'b101;
   localparam logic [2:0] INST_REM  = 3'b110;
   localparam logic [2:0] INST_REMU = 3'b111;

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_CALC = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t                r_state,    w_state_nxt;
   logic [2:0]            r_op,       w_op_nxt;
   logic [AddrWidth-1:0]  r_waddr,    w_waddr_nxt;
   logic [DataWidth-1:0]  r_quot,     w_quot_nxt;
   logic [DataWidth-1:0]  r_rem,      w_rem_nxt;
   logic [DataWidth-1:0]  r_divisor,  w_divisor_nxt;
   logic [CntWidth-1:0]   r_count,    w_count_nxt;
   logic                  r_sign_q,   w_sign_q_nxt;
   logic                  r_sign_r,   w_sign_r_nxt;
   logic                  r_ready,    w_ready_nxt;
   logic [DataWidth-1:0]  r_result,   w_result_nxt;
   logic [AddrWidth-1:0]  r_waddr_o,  w_waddr_o_nxt;

   logic                  w_req_signed;
   logic                  w_req_rem;
   logic                  w_cur_rem;
   logic [DataWidth-1:0]  w_dividend_mag;
   logic [DataWidth-1:0]  w_divisor_mag;
   logic [DataWidth:0]    w_shift;
   logic                  w_ge;
   logic [DataWidth-1:0]  w_rem_iter;
   logic [DataWidth-1:0]  w_quot_iter;
   logic [DataWidth-1:0]  w_q_final;
   logic [DataWidth-1:0]  w_r_final;

   // Request decode and operand magnitudes for the signed ops
   always_comb begin
      w_req_signed   = (op_i == INST_DIV) || (op_i == INST_REM);
      w_req_rem      = (op_i == INST_REM) || (op_i == INST_REMU);
      w_cur_rem      = (r_op == INST_REM) || (r_op == INST_REMU);
      w_dividend_mag = dividend_i[DataWidth-1] ? ((~dividend_i) + DataWidth'(1)) : dividend_i;
      w_divisor_mag  = divisor_i[DataWidth-1]  ? ((~divisor_i)  + DataWidth'(1)) : divisor_i;
   end

   // One restoring-division step plus sign fix-up of the would-be final result
   always_comb begin
      w_shift     = {r_rem, r_quot[DataWidth-1]};
      w_ge        = (w_shift >= {1'b0, r_divisor});
      // when w_ge the difference is below the divisor, so the low bits are exact
      w_rem_iter  = w_ge ? (w_shift[DataWidth-1:0] - r_divisor) : w_shift[DataWidth-1:0];
      w_quot_iter = {r_quot[DataWidth-2:0], w_ge};
      w_q_final   = r_sign_q ? ((~w_quot_iter) + DataWidth'(1)) : w_quot_iter;
      w_r_final   = r_sign_r ? ((~w_rem_iter)  + DataWidth'(1)) : w_rem_iter;
   end

   // Next-state and next-register logic; flush overrides everything
   always_comb begin
      w_state_nxt   = r_state;
      w_op_nxt      = r_op;
      w_waddr_nxt   = r_waddr;
      w_quot_nxt    = r_quot;
      w_rem_nxt     = r_rem;
      w_divisor_nxt = r_divisor;
      w_count_nxt   = r_count;
      w_sign_q_nxt  = r_sign_q;
      w_sign_r_nxt  = r_sign_r;
      w_ready_nxt   = 1'b0;
      w_result_nxt  = r_result;
      w_waddr_o_nxt = r_waddr_o;

      case (r_state)
         S_IDLE: begin
            if (start_i && !flush_i) begin
               w_op_nxt    = op_i;
               w_waddr_nxt = reg_waddr_i;
               if (divisor_i == '0) begin
                  // divide by zero: result known immediately
                  w_quot_nxt    = '1;
                  w_rem_nxt     = dividend_i;
                  w_divisor_nxt = '0;
                  w_sign_q_nxt  = 1'b0;
                  w_sign_r_nxt  = 1'b0;
                  w_count_nxt   = '0;
                  w_ready_nxt   = 1'b1;
                  w_result_nxt  = w_req_rem ? dividend_i : '1;
                  w_waddr_o_nxt = reg_waddr_i;
                  w_state_nxt   = S_DONE;
               end else begin
                  w_quot_nxt    = w_req_signed ? w_dividend_mag : dividend_i;
                  w_divisor_nxt = w_req_signed ? w_divisor_mag  : divisor_i;
                  w_sign_q_nxt  = w_req_signed && (dividend_i[DataWidth-1] ^ divisor_i[DataWidth-1]);
                  w_sign_r_nxt  = w_req_signed && dividend_i[DataWidth-1];
                  w_rem_nxt     = '0;
                  w_count_nxt   = '0;
                  w_state_nxt   = S_CALC;
               end
            end
         end
         S_CALC: begin
            w_quot_nxt  = w_quot_iter;
            w_rem_nxt   = w_rem_iter;
            w_count_nxt = r_count + CntWidth'(1);
            if (r_count == LastCount) begin
               w_ready_nxt   = 1'b1;
               w_result_nxt  = w_cur_rem ? w_r_final : w_q_final;
               w_waddr_o_nxt = r_waddr;
               w_state_nxt   = S_DONE;
            end
         end
         S_DONE: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      if (flush_i) begin
         w_state_nxt   = S_IDLE;
         w_ready_nxt   = 1'b0;
         w_result_nxt  = r_result;
         w_waddr_o_nxt = r_waddr_o;
      end
   end

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   // Datapath and output registers
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_op      <= '0;
         r_waddr   <= '0;
         r_quot    <= '0;
         r_rem     <= '0;
         r_divisor <= '0;
         r_count   <= '0;
         r_sign_q  <= 1'b0;
         r_sign_r  <= 1'b0;
         r_ready   <= 1'b0;
         r_result  <= '0;
         r_waddr_o <= '0;
      end else begin
         r_op      <= w_op_nxt;
         r_waddr   <= w_waddr_nxt;
         r_quot    <= w_quot_nxt;
         r_rem     <= w_rem_nxt;
         r_divisor <= w_divisor_nxt;
         r_count   <= w_count_nxt;
         r_sign_q  <= w_sign_q_nxt;
         r_sign_r  <= w_sign_r_nxt;
         r_ready   <= w_ready_nxt;
         r_result  <= w_result_nxt;
         r_waddr_o <= w_waddr_o_nxt;
      end
   end

   // Busy covers the request cycle so execute stalls without a bubble
   assign busy_o  = !rst && (((r_state == S_IDLE) && start_i && !flush_i) || (r_state == S_CALC));
   // A flush in the DONE cycle suppresses the pending write-back pulse
   assign ready_o = r_ready && !flush_i;
   assign result_o    = r_result;
   assign reg_waddr_o = r_waddr_o;

endmodule

// File: tb/tb_div_unit.sv
// tb_div_unit: scoreboard bench for div_unit.
module tb_div_unit;

   localparam logic [2:0] OP_DIV  = 3'b100;
   localparam logic [2:0] OP_DIVU = 3'b101;
   localparam logic [2:0] OP_REM  = 3'b110;
   localparam logic [2:0] OP_REMU = 3'b111;

   typedef struct packed {
      logic [31:0] res;
      logic [4:0]  wa;
   } exp_t;

   logic        clk;
   logic        rst;
   logic        start_i;
   logic [2:0]  op_i;
   logic [31:0] dividend_i;
   logic [31:0] divisor_i;
   logic [4:0]  reg_waddr_i;
   logic        flush_i;
   logic        busy_o;
   logic        ready_o;
   logic [31:0] result_o;
   logic [4:0]  reg_waddr_o;

   exp_t sb_q[$];
   int   checks;
   int   failures;

   div_unit #(.DataWidth(32), .AddrWidth(5)) dut (
      .clk         (clk),
      .rst         (rst),
      .start_i     (start_i),
      .op_i        (op_i),
      .dividend_i  (dividend_i),
      .divisor_i   (divisor_i),
      .reg_waddr_i (reg_waddr_i),
      .flush_i     (flush_i),
      .busy_o      (busy_o),
      .ready_o     (ready_o),
      .result_o    (result_o),
      .reg_waddr_o (reg_waddr_o)
   );

   always #5 clk = ~clk;

   // RISC-V reference semantics, including divide-by-zero and overflow
   function automatic logic [31:0] ref_res(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
      logic ovf;
      ovf = (a == 32'h8000_0000) && (b == 32'hFFFF_FFFF);
      if (b == 32'd0) return op[1] ? a : 32'hFFFF_FFFF;
      case (op)
         OP_DIV:  return ovf ? 32'h8000_0000 : 32'($signed(a) / $signed(b));
         OP_DIVU: return a / b;
         OP_REM:  return ovf ? 32'd0 : 32'($signed(a) % $signed(b));
         default: return a % b;
      endcase
   endfunction

   // Drive one request, push its expectation, wait (bounded) for ready_o
   task automatic run_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                         input logic [4:0] rd, input bit hold,
                         output int lat, output bit got, output logic [31:0] res,
                         output logic [4:0] wa, output int busy_drops,
                         output logic busy_rdy, output logic rdy_after);
      exp_t e;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = op; dividend_i = a; divisor_i = b; reg_waddr_i = rd;
      e.res = ref_res(op, a, b);
      e.wa  = rd;
      sb_q.push_back(e);
      lat = 0; got = 1'b0; res = '0; wa = '0; busy_drops = 0; busy_rdy = 1'b1; rdy_after = 1'b1;
      while ((lat < 64) && !got) begin
         @(negedge clk);
         if (ready_o === 1'b1) begin
            got = 1'b1; res = result_o; wa = reg_waddr_o; busy_rdy = busy_o;
            start_i = 1'b0;
         end else begin
            if (busy_o !== 1'b1) busy_drops++;
            @(posedge clk); #1;
            lat++;
            if (!hold) begin
               start_i = 1'b0;
            end else begin
               dividend_i = $urandom; divisor_i = $urandom; reg_waddr_i = 5'($urandom);
            end
         end
      end
      start_i = 1'b0;
      if (got) begin
         @(negedge clk);
         rdy_after = ready_o;
      end
   endtask

   task automatic test_reset();
      rst = 1'b1;
      repeat (3) @(posedge clk);
      @(negedge clk);
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL reset_ready got=%b exp=0", ready_o); end
      checks++; if (result_o !== 32'd0) begin failures++; $display("FAIL reset_result got=%h exp=0", result_o); end
      checks++; if (reg_waddr_o !== 5'd0) begin failures++; $display("FAIL reset_waddr got=%0d exp=0", reg_waddr_o); end
      start_i = 1'b1; op_i = OP_DIVU; divisor_i = 32'd3;
      #1;
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL reset_busy got=%b exp=0", busy_o); end
      start_i = 1'b0;
      rst = 1'b0;
   endtask

   task automatic test_divu_basic();
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      run_op(OP_DIVU, 32'd100, 32'd7, 5'd5, 1'b0, lat, got, res, wa, drops, brdy, rafter);
      e = sb_q.pop_front();
      checks++; if (!got) begin failures++; $display("FAIL divu_timeout got=no_ready exp=ready"); end
      checks++; if (lat != 33) begin failures++; $display("FAIL divu_latency got=%0d exp=33", lat); end
      checks++; if (res !== e.res) begin failures++; $display("FAIL divu_result got=%h exp=%h", res, e.res); end
      checks++; if (wa !== e.wa) begin failures++; $display("FAIL divu_waddr got=%0d exp=%0d", wa, e.wa); end
      checks++; if (drops != 0) begin failures++; $display("FAIL divu_busy_gap got=%0d exp=0", drops); end
      checks++; if (brdy !== 1'b0) begin failures++; $display("FAIL divu_busy_in_ready got=%b exp=0", brdy); end
      checks++; if (rafter !== 1'b0) begin failures++; $display("FAIL divu_ready_width got=%b exp=0", rafter); end
   endtask

   task automatic test_signed();
      logic [2:0]  ops [8];
      logic [31:0] as  [8];
      logic [31:0] bs  [8];
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      ops = '{OP_DIV, OP_REM, OP_REMU, OP_REM, OP_DIV, OP_DIVU, OP_REM, OP_DIVU};
      as  = '{32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'hFFFF_FFF9, 32'd7, 32'hFFFF_FF9C, 32'hFFFF_FFFF, $urandom, $urandom};
      bs  = '{32'd2, 32'd2, 32'd2, 32'hFFFF_FFFE, 32'hFFFF_FFF9, 32'd1, $urandom | 32'd1, 32'd13};
      for (int i = 0; i < 8; i++) begin
         run_op(ops[i], as[i], bs[i], 5'(i + 8), 1'b0, lat, got, res, wa, drops, brdy, rafter);
         e = sb_q.pop_front();
         checks++; if (res !== e.res) begin failures++; $display("FAIL signed_result[%0d] got=%h exp=%h", i, res, e.res); end
         checks++; if (wa !== e.wa) begin failures++; $display("FAIL signed_waddr[%0d] got=%0d exp=%0d", i, wa, e.wa); end
         checks++; if (lat != 33) begin failures++; $display("FAIL signed_latency[%0d] got=%0d exp=33", i, lat); end
      end
   endtask

   task automatic test_div_zero();
      logic [2:0]  ops [4];
      logic [31:0] as  [4];
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      ops = '{OP_DIV, OP_REMU, OP_DIV, OP_REM};
      as  = '{32'h0000_1234, 32'h0000_1234, 32'h8000_0000, 32'hFFFF_FFFB};
      for (int i = 0; i < 4; i++) begin
         run_op(ops[i], as[i], 32'd0, 5'(i + 20), 1'b0, lat, got, res, wa, drops, brdy, rafter);
         e = sb_q.pop_front();
         checks++; if (res !== e.res) begin failures++; $display("FAIL dz_result[%0d] got=%h exp=%h", i, res, e.res); end
         checks++; if (wa !== e.wa) begin failures++; $display("FAIL dz_waddr[%0d] got=%0d exp=%0d", i, wa, e.wa); end
         checks++; if (lat != 1) begin failures++; $display("FAIL dz_latency[%0d] got=%0d exp=1", i, lat); end
         checks++; if (rafter !== 1'b0) begin failures++; $display("FAIL dz_ready_width[%0d] got=%b exp=0", i, rafter); end
      end
   endtask

   task automatic test_overflow();
      logic [2:0] ops [2];
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      ops = '{OP_DIV, OP_REM};
      for (int i = 0; i < 2; i++) begin
         run_op(ops[i], 32'h8000_0000, 32'hFFFF_FFFF, 5'd31, 1'b0, lat, got, res, wa, drops, brdy, rafter);
         e = sb_q.pop_front();
         checks++; if (res !== e.res) begin failures++; $display("FAIL ovf_result[%0d] got=%h exp=%h", i, res, e.res); end
         checks++; if (lat != 33) begin failures++; $display("FAIL ovf_latency[%0d] got=%0d exp=33", i, lat); end
      end
   endtask

   task automatic test_hold_start();
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      run_op(OP_DIV, 32'hFFFF_FC18, 32'd37, 5'd17, 1'b1, lat, got, res, wa, drops, brdy, rafter);
      e = sb_q.pop_front();
      checks++; if (res !== e.res) begin failures++; $display("FAIL hold_result got=%h exp=%h", res, e.res); end
      checks++; if (wa !== e.wa) begin failures++; $display("FAIL hold_waddr got=%0d exp=%0d", wa, e.wa); end
      checks++; if (lat != 33) begin failures++; $display("FAIL hold_latency got=%0d exp=33", lat); end
   endtask

   task automatic test_back_to_back();
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      for (int i = 0; i < 3; i++) begin
         run_op(OP_REMU, $urandom, 32'd1000 + 32'(i), 5'(i + 1), 1'b0, lat, got, res, wa, drops, brdy, rafter);
         e = sb_q.pop_front();
         checks++; if (res !== e.res) begin failures++; $display("FAIL b2b_result[%0d] got=%h exp=%h", i, res, e.res); end
         checks++; if (wa !== e.wa) begin failures++; $display("FAIL b2b_waddr[%0d] got=%0d exp=%0d", i, wa, e.wa); end
      end
   endtask

   task automatic test_flush();
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      // flush in CALC at count 10
      @(posedge clk); #1;
      start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd1000; divisor_i = 32'd3; reg_waddr_i = 5'd7;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (10) @(posedge clk);
      #1;
      flush_i = 1'b1;
      @(negedge clk);
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL flush_calc_ready got=%b exp=0", ready_o); end
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_calc_busy got=%b exp=0", busy_o); end
      run_op(OP_DIVU, 32'd9, 32'd3, 5'd3, 1'b0, lat, got, res, wa, drops, brdy, rafter);
      e = sb_q.pop_front();
      checks++; if (res !== e.res) begin failures++; $display("FAIL flush_next_result got=%h exp=%h", res, e.res); end
      checks++; if (lat != 33) begin failures++; $display("FAIL flush_next_latency got=%0d exp=33", lat); end
      // flush in DONE suppresses the pulse
      @(posedge clk); #1;
      start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd5; divisor_i = 32'd0; reg_waddr_i = 5'd4;
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b1;
      @(negedge clk);
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL flush_done_ready got=%b exp=0", ready_o); end
      @(posedge clk); #1;
      flush_i = 1'b0;
      @(negedge clk);
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL flush_done_late got=%b exp=0", ready_o); end
      // start together with flush is ignored
      @(posedge clk); #1;
      start_i = 1'b1; flush_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'd8; divisor_i = 32'd0;
      @(negedge clk);
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL flush_start_busy got=%b exp=0", busy_o); end
      @(posedge clk); #1;
      start_i = 1'b0; flush_i = 1'b0;
      @(negedge clk);
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL flush_start_ready got=%b exp=0", ready_o); end
   endtask

   task automatic test_async_reset();
      int lat, drops; bit got; logic [31:0] res; logic [4:0] wa; logic brdy, rafter; exp_t e;
      @(posedge clk); #1;
      start_i = 1'b1; op_i = OP_DIVU; dividend_i = 32'hFFFF_0000; divisor_i = 32'd3; reg_waddr_i = 5'd9;
      @(posedge clk); #1;
      start_i = 1'b0;
      repeat (20) @(posedge clk);
      #2;
      rst = 1'b1;
      #1;
      checks++; if (ready_o !== 1'b0) begin failures++; $display("FAIL arst_ready got=%b exp=0", ready_o); end
      checks++; if (result_o !== 32'd0) begin failures++; $display("FAIL arst_result got=%h exp=0", result_o); end
      checks++; if (reg_waddr_o !== 5'd0) begin failures++; $display("FAIL arst_waddr got=%0d exp=0", reg_waddr_o); end
      checks++; if (busy_o !== 1'b0) begin failures++; $display("FAIL arst_busy got=%b exp=0", busy_o); end
      @(negedge clk);
      rst = 1'b0;
      run_op(OP_DIV, 32'hFFFF_FF9C, 32'd7, 5'd11, 1'b0, lat, got, res, wa, drops, brdy, rafter);
      e = sb_q.pop_front();
      checks++; if (res !== e.res) begin failures++; $display("FAIL arst_next_result got=%h exp=%h", res, e.res); end
      checks++; if (wa !== e.wa) begin failures++; $display("FAIL arst_next_waddr got=%0d exp=%0d", wa, e.wa); end
      checks++; if (lat != 33) begin failures++; $display("FAIL arst_next_latency got=%0d exp=33", lat); end
   endtask

   initial begin
      clk = 1'b0; rst = 1'b1; start_i = 1'b0; op_i = OP_DIVU;
      dividend_i = '0; divisor_i = '0; reg_waddr_i = '0; flush_i = 1'b0;
      checks = 0; failures = 0;
      test_reset();
      test_divu_basic();
      test_signed();
      test_div_zero();
      test_overflow();
      test_hold_start();
      test_back_to_back();
      test_flush();
      test_async_reset();
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global guard so the run always ends
   initial begin
      #500000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1);
   end

endmodule
